mc_datapath_regs: RTL and testbench
===================================

# mc_datapath_regs

Architectural and inter-cycle register stage of the multicycle MIPS core. It holds the control FSM state register that feeds `mainController` (`state` out, `NS` in). It also consumes that controller's PC/IR/memory-address controls to maintain PC, IR, MDR, A, B and ALUOut, and applies a memory wait-state stall. It sits between `mainController`, the ALU, the register file and the unified memory port.

## Interface
Parameters:
- `WIDTH`, 32, datapath width.
- `RESET_PC`, 32'h0000_0000, PC value after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `NS`  in  4  next state from `mainController`.
- `PCWrite`, `PCWriteCond`, `IorD`, `IRWrite`, `MemRead`, `MemWrite`  in  1 each  controller outputs.
- `PCSource`  in  2  {PCSource1, PCSource0}.
- `zero`  in  1  ALU zero flag.
- `alu_result`  in  WIDTH  ALU output, current cycle.
- `mem_rdata`  in  WIDTH  memory read data.
- `mem_ready`  in  1  memory access completes this cycle.
- `rf_rdata1`, `rf_rdata2`  in  WIDTH  register file read ports.
- `state`  out  4  current FSM state, drives `mainController`.
- `pc`, `ir`, `mdr`, `a`, `b`, `alu_out`  out  WIDTH  registered values.
- `mem_addr`  out  WIDTH  `IorD ? alu_out : pc`, combinational.
- `opcode` (6), `funct` (6), `rs`/`rt`/`rd` (5), `imm` (16)  out  IR field slices.
- `stall`  out  1  `(MemRead | MemWrite) & ~mem_ready`, combinational.
- `instr_count`  out  32  retired instructions.

## Operation
- Reset (async, `rst_n`=0) sets `state`=0 (FETCH), `pc`=RESET_PC, all other registers to 0, and `instr_count`=0. Combinational outputs follow from these values.
- State register: `state <= NS` every edge unless `stall`=1, in which case it holds.
- PC enable: `pc_en = (PCWrite | (PCWriteCond & zero)) & ~stall`.
- PC next value by `PCSource`:
  - 00: `alu_result`
  - 01: `alu_out`
  - 10: `{pc[31:28], ir[25:0], 2'b00}`
  - 11: reserved, PC holds even when `pc_en`=1.
- IR loads `mem_rdata` when `IRWrite & ~stall`.
- MDR loads `mem_rdata` every non-stalled cycle.
- A, B and ALUOut load `rf_rdata1`, `rf_rdata2` and `alu_result` every non-stalled cycle. During a stall they hold.
- `instr_count` increments by 1, with wrap at 2^32, on each non-stalled edge where `state`≠0 and `NS`=0.
- Simultaneous PC write and IR write in FETCH is legal: both use pre-edge values.
- Reset asserted mid-instruction abandons it immediately: no partial write survives and `instr_count` does not increment.
- All arithmetic is unsigned and WIDTH-bit. No sign extension happens here; `imm` is raw.

## Timing
- Every registered output updates on the rising edge after its enable is sampled high. That is one-cycle latency, with no extra pipeline.
- `mem_addr` and `stall` are same-cycle combinational.
- Memory handshake:
  - The controller holds `MemRead`/`MemWrite` asserted while `stall`=1, since `state` is frozen.
  - The access completes on the first edge with `mem_ready`=1.
  - `mem_rdata` is sampled on that same edge.
- `mem_ready` is ignored when neither `MemRead` nor `MemWrite` is asserted.
- lw executes 0→1→2→3→4→0: 5 cycles with no wait states, plus one cycle per wait state in states 0 and 3.

## Structure
- Package `mc_pkg` holds:
  - State encodings: S_FETCH=0, S_DECODE=1, S_MEMADR=2, S_MEMRD=3, S_MEMWB=4, S_MEMWR=5, S_EXEC=6, S_RCOMP=7, S_BRANCH=8, S_JUMP=9.
  - PCSource codes: PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10.
  - IR field bit positions.
- One sub-module, `mc_en_reg`: parameterized-width enabled register with async active-low reset and a reset-value parameter. It is instantiated for state, PC, IR, MDR, A, B and ALUOut.

## Test plan
- Reset, then release. Check `state`=0, `pc`=0, `ir`=0 and `instr_count`=0, including with `rst_n` asserted asynchronously between edges.
- FETCH: `mem_rdata`=32'h8C22_0004, `IRWrite`=`PCWrite`=1, `PCSource`=00, `alu_result`=4, `mem_ready`=1. After one edge expect `ir`=32'h8C22_0004, `opcode`=6'h23, `pc`=4, `state`=NS.
- lw sequence 0,1,2,3,4,0 driven from NS with `mem_ready`=1. Expect `instr_count`=1 after 5 edges, and `mem_addr`=`alu_out` in state 3.
- Hold `mem_ready`=0 for 2 cycles in FETCH. Expect `stall`=1, with `state`, `pc` and `ir` unchanged for 2 edges. The update occurs on the third edge.
- Branch: `PCWriteCond`=1, `PCSource`=01, `alu_out`=32'h40. With `zero`=0 `pc` is unchanged; with `zero`=1 `pc`=32'h40.
- Jump: `pc`=32'h1000_0010, `ir`=32'h0800_0100, `PCSource`=10, `PCWrite`=1. Expect `pc`=32'h1000_0400.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS datapath register stage:
// controller states, PC source select and instruction field positions.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pcsrc_t;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned TARGET_MSB = 25;
    localparam int unsigned PC_SEG_LSB = 28;

endpackage

// File: rtl/mc_en_reg.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
module mc_en_reg #(
    parameter int unsigned   W       = 32,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/mc_datapath_regs.sv
// Architectural and inter-cycle registers of the multicycle MIPS core:
// FSM state, PC, IR, MDR, A, B, ALUOut, memory wait-state stall and retire count.
module mc_datapath_regs
    import mc_pkg::*;
#(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       NS,
    input  logic             PCWrite,
    input  logic             PCWriteCond,
    input  logic             IorD,
    input  logic             IRWrite,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [1:0]       PCSource,
    input  logic             zero,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] rf_rdata1,
    input  logic [WIDTH-1:0] rf_rdata2,
    output logic [3:0]       state,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] mdr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] mem_addr,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [15:0]      imm,
    output logic             stall,
    output logic [31:0]      instr_count
);

    logic             advance;
    logic             pcEn;
    logic             pcLoad;
    logic [WIDTH-1:0] pcNext;
    pcsrc_t           pcSel;

    assign stall    = (MemRead | MemWrite) & ~mem_ready;
    assign advance  = ~stall;
    assign mem_addr = IorD ? alu_out : pc;

    assign pcEn  = (PCWrite | (PCWriteCond & zero)) & advance;
    assign pcSel = pcsrc_t'(PCSource);

    // Reserved select suppresses the load rather than picking a value.
    always_comb begin
        pcNext = pc;
        pcLoad = pcEn;
        unique case (pcSel)
            PCSRC_ALU:    pcNext = alu_result;
            PCSRC_ALUOUT: pcNext = alu_out;
            PCSRC_JUMP:   pcNext = {pc[WIDTH-1:PC_SEG_LSB], ir[TARGET_MSB:0], 2'b00};
            default:      pcLoad = 1'b0;
        endcase
    end

    mc_en_reg #(.W(4), .RST_VAL(S_FETCH)) stateReg (
        .clk(clk), .rst_n(rst_n), .en(advance), .d(NS), .q(state)
    );

    mc_en_reg #(.W(WIDTH), .RST_VAL(RESET_PC)) pcReg (
        .clk(clk), .rst_n(rst_n), .en(pcLoad), .d(pcNext), .q(pc)
    );

    mc_en_reg #(.W(WIDTH), .RST_VAL('0)) irReg (
        .clk(clk), .rst_n(rst_n), .en(IRWrite & advance), .d(mem_rdata), .q(ir)
    );

    mc_en_reg #(.W(WIDTH), .RST_VAL('0)) mdrReg (
        .clk(clk), .rst_n(rst_n), .en(advance), .d(mem_rdata), .q(mdr)
    );

    mc_en_reg #(.W(WIDTH), .RST_VAL('0)) aReg (
        .clk(clk), .rst_n(rst_n), .en(advance), .d(rf_rdata1), .q(a)
    );

    mc_en_reg #(.W(WIDTH), .RST_VAL('0)) bReg (
        .clk(clk), .rst_n(rst_n), .en(advance), .d(rf_rdata2), .q(b)
    );

    mc_en_reg #(.W(WIDTH), .RST_VAL('0)) aluOutReg (
        .clk(clk), .rst_n(rst_n), .en(advance), .d(alu_result), .q(alu_out)
    );

    // An instruction retires on the edge that returns the FSM to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instr_count <= '0;
        else if (advance && (state_t'(state) != S_FETCH) && (state_t'(NS) == S_FETCH))
            instr_count <= instr_count + 32'd1;
    end

    assign opcode = ir[OPCODE_MSB:OPCODE_LSB];
    assign rs     = ir[RS_MSB:RS_LSB];
    assign rt     = ir[RT_MSB:RT_LSB];
    assign rd     = ir[RD_MSB:RD_LSB];
    assign funct  = ir[FUNCT_MSB:FUNCT_LSB];
    assign imm    = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Scoreboard bench for mc_datapath_regs: expected register snapshots are
// queued when a cycle is driven and compared after the following edge.
module tb_mc_datapath_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  NS;
    logic        PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
    logic [1:0]  PCSource;
    logic        zero;
    logic [31:0] alu_result, mem_rdata, rf_rdata1, rf_rdata2;
    logic        mem_ready;
    logic [3:0]  state;
    logic [31:0] pc, ir, mdr, a, b, alu_out, mem_addr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        stall;
    logic [31:0] instr_count;

    int unsigned nChecks = 0;
    int unsigned nErrors = 0;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [31:0] pc, ir, mdr, a, b, ao, cnt;
    } snap_t;

    snap_t expQ[$];

    // reference model
    logic [3:0]  mState;
    logic [31:0] mPc, mIr, mMdr, mA, mB, mAo, mCnt;

    mc_datapath_regs #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .NS(NS),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .PCSource(PCSource), .zero(zero), .alu_result(alu_result),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .state(state), .pc(pc), .ir(ir), .mdr(mdr), .a(a), .b(b),
        .alu_out(alu_out), .mem_addr(mem_addr), .opcode(opcode),
        .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .stall(stall), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mState = 4'd0; mPc = 32'h0; mIr = '0; mMdr = '0;
        mA = '0; mB = '0; mAo = '0; mCnt = '0;
    endtask

    task automatic setIdle();
        NS = 4'd0; PCWrite = 0; PCWriteCond = 0; IorD = 0; IRWrite = 0;
        MemRead = 0; MemWrite = 0; PCSource = 2'b00; zero = 0;
        alu_result = '0; mem_rdata = '0; rf_rdata1 = '0; rf_rdata2 = '0;
        mem_ready = 1'b1;
    endtask

    task automatic checkSnap(input snap_t e);
        checkVal({e.tag, ".state"},  {28'h0, state}, {28'h0, e.st});
        checkVal({e.tag, ".pc"},     pc,          e.pc);
        checkVal({e.tag, ".ir"},     ir,          e.ir);
        checkVal({e.tag, ".mdr"},    mdr,         e.mdr);
        checkVal({e.tag, ".a"},      a,           e.a);
        checkVal({e.tag, ".b"},      b,           e.b);
        checkVal({e.tag, ".aluout"}, alu_out,     e.ao);
        checkVal({e.tag, ".count"},  instr_count, e.cnt);
        checkVal({e.tag, ".opcode"}, {26'h0, opcode}, {26'h0, e.ir[31:26]});
        checkVal({e.tag, ".rs"},     {27'h0, rs},     {27'h0, e.ir[25:21]});
        checkVal({e.tag, ".rt"},     {27'h0, rt},     {27'h0, e.ir[20:16]});
        checkVal({e.tag, ".rd"},     {27'h0, rd},     {27'h0, e.ir[15:11]});
        checkVal({e.tag, ".funct"},  {26'h0, funct},  {26'h0, e.ir[5:0]});
        checkVal({e.tag, ".imm"},    {16'h0, imm},    {16'h0, e.ir[15:0]});
    endtask

    function automatic snap_t modelSnap(input string tag);
        snap_t s;
        s.tag = tag; s.st = mState; s.pc = mPc; s.ir = mIr; s.mdr = mMdr;
        s.a = mA; s.b = mB; s.ao = mAo; s.cnt = mCnt;
        return s;
    endfunction

    // Call ~1 time unit after a rising edge with inputs already driven.
    task automatic cycle(input string tag);
        logic        stl;
        logic [31:0] nPc;
        snap_t       e;
        #1;
        stl = (MemRead | MemWrite) & ~mem_ready;
        checkVal({tag, ".stall"},   {31'h0, stall}, {31'h0, stl});
        checkVal({tag, ".memaddr"}, mem_addr, IorD ? mAo : mPc);
        if (!stl) begin
            nPc = mPc;
            if (PCWrite | (PCWriteCond & zero)) begin
                case (PCSource)
                    2'b00:   nPc = alu_result;
                    2'b01:   nPc = mAo;
                    2'b10:   nPc = {mPc[31:28], mIr[25:0], 2'b00};
                    default: nPc = mPc;
                endcase
            end
            if (mState != 4'd0 && NS == 4'd0) mCnt = mCnt + 32'd1;
            mPc = nPc;
            if (IRWrite) mIr = mem_rdata;
            mMdr = mem_rdata; mA = rf_rdata1; mB = rf_rdata2; mAo = alu_result;
            mState = NS;
        end
        expQ.push_back(modelSnap(tag));
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkVal({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            checkSnap(e);
        end
    endtask

    initial begin
        // reset with busy inputs: reset must dominate
        rst_n = 1'b0;
        setIdle();
        PCWrite = 1; IRWrite = 1; NS = 4'd5; alu_result = 32'hDEAD_BEEF;
        mem_rdata = 32'h1234_5678; rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkSnap(modelSnap("reset"));
        checkVal("reset.stall", {31'h0, stall}, 32'd0);
        rst_n = 1'b1;
        setIdle();

        // FETCH of lw $2, 4($1)
        NS = 4'd1; MemRead = 1; IRWrite = 1; PCWrite = 1; PCSource = 2'b00;
        alu_result = 32'd4; mem_rdata = 32'h8C22_0004;
        cycle("fetch");
        checkVal("fetch.opcode23", {26'h0, opcode}, 32'h23);
        checkVal("fetch.pc4", pc, 32'd4);

        // DECODE
        setIdle(); NS = 4'd2; rf_rdata1 = 32'h0000_00F0; rf_rdata2 = 32'h55;
        alu_result = 32'h0000_0018;
        cycle("decode");
        // MEMADR
        setIdle(); NS = 4'd3; alu_result = 32'h0000_00F4;
        cycle("memadr");
        // MEMRD: data address from ALUOut
        setIdle(); NS = 4'd4; IorD = 1; MemRead = 1; mem_rdata = 32'hCAFE_0001;
        #1;
        checkVal("memrd.addr_is_aluout", mem_addr, 32'h0000_00F4);
        cycle("memrd");
        // MEMWB -> FETCH retires
        setIdle(); NS = 4'd0;
        cycle("memwb");
        checkVal("lw.count1", instr_count, 32'd1);

        // FETCH with two wait states
        setIdle(); NS = 4'd1; MemRead = 1; IRWrite = 1; PCWrite = 1;
        alu_result = 32'd8; mem_rdata = 32'h0000_0820; mem_ready = 0;
        #1;
        checkVal("wait.stall", {31'h0, stall}, 32'd1);
        cycle("wait1");
        cycle("wait2");
        checkVal("wait.pc_held", pc, 32'd4);
        mem_ready = 1;
        cycle("wait_done");
        checkVal("wait.pc8", pc, 32'd8);

        // mem_ready ignored with no access
        setIdle(); NS = 4'd6; mem_ready = 0; alu_result = 32'h40;
        cycle("noaccess");

        // branch not taken / taken, ALUOut stays 0x40
        setIdle(); NS = 4'd0; PCWriteCond = 1; PCSource = 2'b01; zero = 0; alu_result = 32'h40;
        cycle("beq_nt");
        checkVal("beq_nt.pc", pc, 32'd8);
        setIdle(); NS = 4'd8; alu_result = 32'h40;
        cycle("to_branch");
        setIdle(); NS = 4'd0; PCWriteCond = 1; PCSource = 2'b01; zero = 1; alu_result = 32'h40;
        cycle("beq_t");
        checkVal("beq_t.pc", pc, 32'h40);

        // jump setup: pc and ir loaded together from pre-edge values
        setIdle(); NS = 4'd1; MemRead = 1; IRWrite = 1; PCWrite = 1;
        alu_result = 32'h1000_0010; mem_rdata = 32'h0800_0100;
        cycle("jsetup");
        setIdle(); NS = 4'd0; PCWrite = 1; PCSource = 2'b10;
        cycle("jump");
        checkVal("jump.pc", pc, 32'h1000_0400);

        // reserved PCSource holds PC
        setIdle(); NS = 4'd1; PCWrite = 1; PCSource = 2'b11; alu_result = 32'hFFFF_FFF0;
        cycle("pcsrc_rsvd");

        // randomised traffic
        for (int i = 0; i < 60; i++) begin
            NS = 4'($urandom_range(0, 9));
            PCWrite = 1'($urandom); PCWriteCond = 1'($urandom); IorD = 1'($urandom);
            IRWrite = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
            PCSource = 2'($urandom); zero = 1'($urandom);
            alu_result = $urandom; mem_rdata = $urandom;
            rf_rdata1 = $urandom; rf_rdata2 = $urandom;
            mem_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        // drive to a non-FETCH state, then reset between edges while NS=0
        setIdle(); NS = 4'd4;
        cycle("pre_abort");
        setIdle(); NS = 4'd0; PCWrite = 1; IRWrite = 1; alu_result = 32'h7777_0000;
        mem_rdata = 32'h2345_6789;
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkSnap(modelSnap("async_rst"));
        @(posedge clk);
        #1;
        checkSnap(modelSnap("abort_held"));
        rst_n = 1'b1;
        setIdle(); NS = 4'd1;
        cycle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
